decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe_pkg.sv | 129 ++++++++++++
 rtl/decode_pipe_fifo.sv | 50 +++++
 rtl/decode_pipe.sv | 108 ++++++++++
 tb/tb_decode_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg: shared types and the decode table for decode_pipe.
//   opcode_e        - 4-bit opcode enumeration (IR[15:12])
//   alu_ctrl_e      - alu_control encodings
//   pcsel1_e        - pcselect1 encodings
//   wsel_e          - W_Control (writeback select) encodings
//   E_*             - bit positions inside the 6-bit E_Control word
//   ctrl_t          - decoded control bundle stored per queue entry
//   decode_instr()  - opcode -> control decode table
package decode_pipe_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_RSV4 = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RSVD = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        PC1_NONE  = 2'b00,
        PC1_PCREL = 2'b01,
        PC1_BASE  = 2'b10,
        PC1_JMP   = 2'b11
    } pcsel1_e;

    typedef enum logic [1:0] {
        WB_ALU   = 2'b00,
        WB_PCREL = 2'b01,
        WB_MEM   = 2'b10
    } wsel_e;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int unsigned E_ALU_LSB = 4;
    localparam int unsigned E_PC1_LSB = 2;
    localparam int unsigned E_PC2_BIT = 1;
    localparam int unsigned E_OP2_BIT = 0;

    typedef struct packed {
        logic [5:0] e_control;
        logic [1:0] w_control;
        logic       mem_control;
        logic       illegal;
    } ctrl_t;

    // Queue entry layout is {IR, npc, ctrl}; the IR/npc width follows the
    // DATA_W parameter of decode_pipe, so the full entry struct is declared
    // there on top of ctrl_t.

    // imm_sel is IR[5]: 1 selects imm5, 0 selects the register operand.
    // Unsupported opcodes return all controls 0 with illegal=1.
    function automatic ctrl_t decode_instr(input logic [3:0] opc, input logic imm_sel);
        ctrl_t     c;
        alu_ctrl_e alu;
        pcsel1_e   pc1;
        wsel_e     wsel;
        logic      pc2;
        logic      op2;
        c    = '0;
        alu  = ALU_ADD;
        pc1  = PC1_NONE;
        wsel = WB_ALU;
        pc2  = 1'b0;
        op2  = 1'b0;
        case (opcode_e'(opc))
            OP_ADD: op2 = ~imm_sel;
            OP_AND: begin
                alu = ALU_AND;
                op2 = ~imm_sel;
            end
            OP_NOT: alu = ALU_NOT;
            OP_BR, OP_ST: begin
                pc1 = PC1_PCREL;
                pc2 = 1'b1;
            end
            OP_LD: begin
                pc1  = PC1_PCREL;
                pc2  = 1'b1;
                wsel = WB_MEM;
            end
            OP_LDI: begin
                pc1  = PC1_PCREL;
                pc2  = 1'b1;
                wsel = WB_MEM;
                c.mem_control = 1'b1;
            end
            OP_STI: begin
                pc1 = PC1_PCREL;
                pc2 = 1'b1;
                c.mem_control = 1'b1;
            end
            OP_LEA: begin
                pc1  = PC1_PCREL;
                pc2  = 1'b1;
                wsel = WB_PCREL;
            end
            OP_LDR: begin
                pc1  = PC1_BASE;
                wsel = WB_MEM;
            end
            OP_STR: pc1 = PC1_BASE;
            OP_JMP: pc1 = PC1_JMP;
            default: c.illegal = 1'b1;
        endcase
        c.e_control[E_ALU_LSB +: 2] = alu;
        c.e_control[E_PC1_LSB +: 2] = pc1;
        c.e_control[E_PC2_BIT]      = pc2;
        c.e_control[E_OP2_BIT]      = op2;
        c.w_control                 = wsel;
        return c;
    endfunction

endpackage

// File: rtl/decode_pipe_fifo.sv
// decode_pipe_fifo: DEPTH-entry circular queue of entry_t.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, pop    : qualified write / read strobes (caller guarantees legality)
//   din          : entry written on push
//   dout         : current head entry (valid only when count != 0)
//   count        : number of occupied entries, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap naturally.
module decode_pipe_fifo #(
    parameter type         entry_t = logic [7:0],
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    entry_t           mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: a slot is only observed after it is written.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with a DEPTH-entry output queue.
// Each accepted instruction is decoded on entry and stored with its IR/NPC;
// the head of the queue drives the outputs one cycle after push.
//   clock, reset            : rising-edge clock, async active-high reset
//   en_decode               : stage enable; low freezes queue and outputs
//   in_valid / in_ready     : upstream handshake (instr_dout, npc_in)
//   out_valid / out_ready   : downstream handshake on the queue head
//   IR, npc_out             : head instruction and next PC
//   E_Control               : {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control               : writeback select (00 ALU, 01 PC-rel, 10 memory)
//   Mem_Control             : indirect access (LDI/STI)
//   illegal                 : head opcode unsupported
// Build option: DECODE_PIPE_ILLEGAL_TRAP_EN flags unsupported opcodes on
// illegal; when undefined they pass through as no-ops and illegal stays 0.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_decode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr_dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_Control,
    output logic [1:0]        W_Control,
    output logic              Mem_Control,
    output logic              illegal
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] npc;
        ctrl_t             ctrl;
    } decode_entry_t;

    logic             started;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    ctrl_t            raw_ctrl;
    ctrl_t            in_ctrl;
    decode_entry_t    din;
    decode_entry_t    head;

    // Holds in_ready low until the first clock edge after reset releases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) started <= 1'b0;
        else       started <= 1'b1;
    end

    always_comb begin
        raw_ctrl = decode_instr(instr_dout[15:12], instr_dout[5]);
        in_ctrl  = raw_ctrl;
`ifdef DECODE_PIPE_ILLEGAL_TRAP_EN
        in_ctrl.illegal = raw_ctrl.illegal;
`else
        in_ctrl.illegal = 1'b0;
`endif
    end

    always_comb begin
        din      = '0;
        din.ir   = instr_dout;
        din.npc  = npc_in;
        din.ctrl = in_ctrl;
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign in_ready  = en_decode && started && (!full || out_ready);
    assign push      = en_decode && in_valid && in_ready;
    assign pop       = en_decode && out_valid && out_ready;

    decode_pipe_fifo #(
        .entry_t (decode_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    // Gating with out_valid makes the outputs read 0 whenever the queue is
    // empty, including the instant an asynchronous reset empties it.
    assign IR          = out_valid ? head.ir  : '0;
    assign npc_out     = out_valid ? head.npc : '0;
    assign E_Control   = out_valid ? head.ctrl.e_control : '0;
    assign W_Control   = out_valid ? head.ctrl.w_control : '0;
    assign Mem_Control = out_valid && head.ctrl.mem_control;
    // Without the trap option the stored flag is always written 0.
    assign illegal     = out_valid && head.ctrl.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

    localparam int DEPTH = 2;
`ifdef DECODE_PIPE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        en_decode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
    } ent_t;
    ent_t q[$];

    decode_pipe #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .en_decode   (en_decode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_dout  (instr_dout),
        .npc_in      (npc_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .IR          (IR),
        .npc_out     (npc_out),
        .E_Control   (E_Control),
        .W_Control   (W_Control),
        .Mem_Control (Mem_Control),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    // Reference decode from the opcode table: returns {E[5:0], W[1:0], Mem, illegal}.
    function automatic logic [9:0] model_ctrl(input logic [15:0] instr);
        logic [3:0] op;
        logic [1:0] alu, pc1, w;
        logic       pc2, op2, mem, ill;
        op  = instr[15:12];
        alu = (op == 4'd5) ? 2'd1 : (op == 4'd9) ? 2'd2 : 2'd0;
        op2 = (op inside {4'd1, 4'd5}) && !instr[5];
        pc2 = op inside {4'd0, 4'd2, 4'd3, 4'd10, 4'd11, 4'd14};
        pc1 = pc2 ? 2'd1 : (op inside {4'd6, 4'd7}) ? 2'd2 : (op == 4'd12) ? 2'd3 : 2'd0;
        w   = (op inside {4'd2, 4'd6, 4'd10}) ? 2'd2 : (op == 4'd14) ? 2'd1 : 2'd0;
        mem = op inside {4'd10, 4'd11};
        ill = TRAP && (op inside {4'd4, 4'd8, 4'd13, 4'd15});
        return {alu, pc1, pc2, op2, w, mem, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic en, input logic ordy);
        logic [9:0]  c;
        logic [15:0] eir, enpc;
        logic        rdy;
        rdy = en && (q.size() < DEPTH || (q.size() == DEPTH && ordy));
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            eir  = q[0].ir;
            enpc = q[0].npc;
            c    = model_ctrl(eir);
        end else begin
            eir  = '0;
            enpc = '0;
            c    = '0;
        end
        chk("IR", IR, eir);
        chk("npc_out", npc_out, enpc);
        chk("E_Control", E_Control, c[9:4]);
        chk("W_Control", W_Control, c[3:2]);
        chk("Mem_Control", Mem_Control, c[1]);
        chk("illegal", illegal, c[0]);
    endtask

    // One clock: drive, check mid-cycle, clock, then advance the model.
    task automatic step(input logic en, input logic iv, input logic [15:0] instr,
                        input logic [15:0] npc, input logic ordy);
        logic do_push, do_pop, rdy;
        en_decode  = en;
        in_valid   = iv;
        instr_dout = instr;
        npc_in     = npc;
        out_ready  = ordy;
        #2;
        check_outputs(en, ordy);
        rdy     = en && (q.size() < DEPTH || (q.size() == DEPTH && ordy));
        do_push = en && iv && rdy;
        do_pop  = en && (q.size() != 0) && ordy;
        @(posedge clock);
        #1;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back('{ir: instr, npc: npc});
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) step(1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_IR"}, IR, 0);
        chk({tag, "_npc"}, npc_out, 0);
        chk({tag, "_E"}, E_Control, 0);
        chk({tag, "_W"}, W_Control, 0);
        chk({tag, "_Mem"}, Mem_Control, 0);
        chk({tag, "_illegal"}, illegal, 0);
    endtask

    initial begin
        reset      = 1'b1;
        en_decode  = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        instr_dout = 16'h1261;
        npc_in     = 16'h3001;
        #2;
        check_all_zero("reset");
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("ready_before_first_edge", in_ready, 0);
        @(posedge clock);
        #1;

        // ADD immediate
        step(1'b1, 1'b1, 16'h1261, 16'h3001, 1'b0);
        chk("add_IR", IR, 16'h1261);
        chk("add_npc", npc_out, 16'h3001);
        chk("add_E", E_Control, 6'b000000);
        chk("add_W", W_Control, 2'b00);
        chk("add_Mem", Mem_Control, 0);
        drain();

        // LDI
        step(1'b1, 1'b1, 16'hA005, 16'h4000, 1'b0);
        chk("ldi_E", E_Control, 6'b000110);
        chk("ldi_W", W_Control, 2'b10);
        chk("ldi_Mem", Mem_Control, 1);
        drain();

        // Full queue, then simultaneous push/pop while full
        step(1'b1, 1'b1, 16'h1042, 16'h0101, 1'b0);
        step(1'b1, 1'b1, 16'h5083, 16'h0102, 1'b0);
        step(1'b1, 1'b1, 16'h6184, 16'h0103, 1'b0);
        chk("full_in_ready", in_ready, 0);
        step(1'b1, 1'b1, 16'hC1C0, 16'h0104, 1'b1);
        out_ready = 1'b0;
        #1;
        chk("swap_still_full", in_ready, 0);
        chk("swap_valid", out_valid, 1);
        chk("swap_head", IR, 16'h5083);

        // Freeze with out_ready high
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
        chk("freeze_head", IR, 16'h5083);
        chk("freeze_npc", npc_out, 16'h0102);
        drain();

        // Unsupported opcode
        step(1'b1, 1'b1, 16'hD000, 16'h1234, 1'b0);
        chk("ill_flag", illegal, TRAP);
        chk("ill_E", E_Control, 0);
        chk("ill_W", W_Control, 0);
        chk("ill_Mem", Mem_Control, 0);
        chk("ill_IR", IR, 16'hD000);
        drain();

        // Every opcode, both IR[5] values
        for (int op = 0; op < 16; op++) begin
            step(1'b1, 1'b1, {4'(op), 12'h020}, 16'(op), 1'b1);
            step(1'b1, 1'b1, {4'(op), 12'h01F}, 16'(op + 100), 1'b1);
        end
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 7) != 0, 1'($urandom), 16'($urandom),
                 16'($urandom), $urandom_range(0, 2) != 0);

        // Reset mid-operation with two entries queued
        drain();
        step(1'b1, 1'b1, 16'h2ABC, 16'h5001, 1'b0);
        step(1'b1, 1'b1, 16'hE123, 16'h5002, 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        out_ready = 1'b1;
        reset     = 1'b1;
        #1;
        check_all_zero("midreset");
        q.delete();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("ready_after_midreset", in_ready, 0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
